// File: rtl/missile_defs.sv
// Shared widths, defaults and launcher state encoding for the missile
// scheduler, slot and any drawing/collision blocks.
package missile_defs;

  localparam int POS_W           = 10;
  localparam int HC_W            = 8;
  localparam int HC_MAX          = 255;
  localparam int MAX_SLOTS       = 8;
  localparam int DEF_BLOCK_Y     = 100;
  localparam int DEF_BLOCK_X_MAX = 600;
  localparam int DEF_COOLDOWN    = 32;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_COOL  = 1'b1
  } launch_st_e;

  function automatic logic [3:0] popcount(
    input logic [MAX_SLOTS-1:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/missile_slot.sv
// One missile: loads at launch, climbs one row per tick, and retires
// on a block hit or when it reaches row 0.
module missile_slot
  import missile_defs::*;
#(
  parameter int BLOCK_Y     = DEF_BLOCK_Y,
  parameter int BLOCK_X_MAX = DEF_BLOCK_X_MAX
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  pos_t apx_i,
  input  pos_t apy_i,
  output pos_t mpx_o,
  output pos_t mpy_o,
  output logic active_o,
  output logic hit_o
);

  localparam int   XLIM = (1 << POS_W) - 1;
  localparam pos_t ROW  = pos_t'(BLOCK_Y);
  localparam pos_t XMAX =
    (BLOCK_X_MAX > XLIM) ? pos_t'(XLIM) : pos_t'(BLOCK_X_MAX);

  pos_t mpx_q, mpx_d;
  pos_t mpy_q, mpy_d;
  logic active_q, active_d;
  logic at_row;

  assign at_row   = (mpx_q <= XMAX) && (mpy_q == ROW);
  assign hit_o    = active_q && at_row;
  assign mpx_o    = mpx_q;
  assign mpy_o    = mpy_q;
  assign active_o = active_q;

  // Flight step: hit beats floor-retire beats climbing.
  always_comb begin
    mpx_d    = mpx_q;
    mpy_d    = mpy_q;
    active_d = active_q;
    if (load_i) begin
      mpx_d    = apx_i;
      mpy_d    = apy_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (at_row) begin
        active_d = 1'b0;
      end else if (mpy_q == '0) begin
        active_d = 1'b0;
      end else begin
        mpy_d = mpy_q - pos_t'(1);
      end
    end
  end

  // Position and flight flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mpx_q    <= '0;
      mpy_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mpx_q    <= mpx_d;
      mpy_q    <= mpy_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/missile_scheduler.sv
// Fire-key launcher: edge-detects fire, enforces a cooldown, hands
// launches to free slots round-robin and tallies block hits.
module missile_scheduler
  import missile_defs::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int BLOCK_Y     = DEF_BLOCK_Y,
  parameter int BLOCK_X_MAX = DEF_BLOCK_X_MAX,
  parameter int COOLDOWN    = DEF_COOLDOWN
) (
  input  logic                       game_clk,
  input  logic                       reset_n,
  input  logic                       fire_n,
  input  logic [POS_W-1:0]           apx,
  input  logic [POS_W-1:0]           apy,
  output logic [NUM_SLOTS*POS_W-1:0] mpx_flat,
  output logic [NUM_SLOTS*POS_W-1:0] mpy_flat,
  output logic [NUM_SLOTS-1:0]       active,
  output logic [NUM_SLOTS-1:0]       hit_mask,
  output logic                       hit,
  output logic                       fire_ack,
  output logic                       fire_drop,
  output logic [HC_W-1:0]            hit_count
);

  localparam int PTR_W = $clog2(NUM_SLOTS);
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CD_W-1:0]  cd_t;

  localparam cd_t CD_LOAD = cd_t'(COOLDOWN - 1);

  launch_st_e      st_q, st_d;
  cd_t             cd_q, cd_d;
  ptr_t            rr_q, rr_d;
  ptr_t            sel;
  logic            sel_ok;
  logic            fire_q;
  logic            fire_edge;
  logic            accept;
  logic            ack_q, drop_q;
  logic [HC_W-1:0] hc_q, hc_d;
  logic [HC_W:0]   hc_sum;
  logic [NUM_SLOTS-1:0] load;

  assign fire_edge = fire_q & ~fire_n;
  assign accept    = fire_edge && (st_q == ST_READY) && sel_ok;

  // First free slot at or after rr_q; reverse scan so nearest wins.
  always_comb begin
    sel    = rr_q;
    sel_ok = 1'b0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!active[rr_q + ptr_t'(k)]) begin
        sel    = rr_q + ptr_t'(k);
        sel_ok = 1'b1;
      end
    end
  end

  // Launcher FSM; READY returns as the counter lands on zero.
  always_comb begin
    st_d = st_q;
    cd_d = cd_q;
    rr_d = rr_q;
    unique case (st_q)
      ST_READY: begin
        if (accept) begin
          st_d = ST_COOL;
          cd_d = CD_LOAD;
          rr_d = sel + ptr_t'(1);
        end
      end
      ST_COOL: begin
        if (cd_q <= cd_t'(1)) begin
          st_d = ST_READY;
          cd_d = '0;
        end else begin
          cd_d = cd_q - cd_t'(1);
        end
      end
      default: st_d = ST_READY;
    endcase
  end

  assign hc_sum = {1'b0, hc_q}
                + (HC_W+1)'(popcount(MAX_SLOTS'(hit_mask)));
  assign hc_d   = (hc_sum > (HC_W+1)'(HC_MAX))
                ? HC_W'(HC_MAX) : hc_sum[HC_W-1:0];

  // Launcher state, fire history, pulses and hit tally.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= ST_READY;
      cd_q   <= '0;
      rr_q   <= '0;
      fire_q <= 1'b1;
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      hc_q   <= '0;
    end else begin
      st_q   <= st_d;
      cd_q   <= cd_d;
      rr_q   <= rr_d;
      fire_q <= fire_n;
      ack_q  <= accept;
      drop_q <= fire_edge & ~accept;
      hc_q   <= hc_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign load[g] = accept && (sel == ptr_t'(g));

    missile_slot #(
      .BLOCK_Y     (BLOCK_Y),
      .BLOCK_X_MAX (BLOCK_X_MAX)
    ) u_slot (
      .clk_i    (game_clk),
      .rst_ni   (reset_n),
      .load_i   (load[g]),
      .apx_i    (apx),
      .apy_i    (apy),
      .mpx_o    (mpx_flat[g*POS_W +: POS_W]),
      .mpy_o    (mpy_flat[g*POS_W +: POS_W]),
      .active_o (active[g]),
      .hit_o    (hit_mask[g])
    );
  end

  assign hit       = |hit_mask;
  assign fire_ack  = ack_q;
  assign fire_drop = drop_q;
  assign hit_count = hc_q;

endmodule
